// File: rtl/sp_ram_ctrl_if.sv
// rtl/sp_ram_ctrl_if.sv - request/response streams and RAM port of the single-port RAM controller
interface sp_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_bw;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_di;
  logic [DATA_WIDTH-1:0] mem_bw;
  logic                  mem_ce;
  logic                  mem_rdwen;
  logic [DATA_WIDTH-1:0] mem_do;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bw, rsp_ready, mem_do,
    output req_ready, rsp_valid, rsp_rdata, init_done,
    output mem_a, mem_di, mem_bw, mem_ce, mem_rdwen
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bw, rsp_ready, mem_do,
    input  req_ready, rsp_valid, rsp_rdata, init_done,
    input  mem_a, mem_di, mem_bw, mem_ce, mem_rdwen
  );
endinterface

// File: rtl/sp_ram_ctrl.sv
// rtl/sp_ram_ctrl.sv - single-port RAM requester with optional zero-fill and credit-based response FIFO
module sp_ram_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 3,
  parameter int INIT_ZERO  = 1
) (
  input  logic        clk,
  input  logic        rst,
  sp_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW:0]           CREDITS  = (CW + 1)'(RSP_DEPTH);
  localparam logic [PW-1:0]         PTR_LAST = PW'(RSP_DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic                  rd_inflight;
  logic                  credit, accept, push, pop;

  // A read in flight has a FIFO slot reserved, so a push can never overflow.
  assign credit = ({1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight}) < CREDITS;
  assign push   = rd_inflight;
  assign pop    = bus.rsp_valid & bus.rsp_ready;

  assign bus.rsp_valid = ~rst & (fifo_count != '0);
  assign bus.rsp_rdata = fifo_mem[rd_ptr];
  assign bus.init_done = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.mem_ce    = 1'b0;
    bus.mem_rdwen = 1'b0;
    bus.mem_a     = '0;
    bus.mem_di    = '0;
    bus.mem_bw    = '0;
    if (!rst) begin
      unique case (state)
        S_INIT: begin
          if (INIT_ZERO != 0) begin
            bus.mem_ce    = 1'b1;
            bus.mem_rdwen = 1'b1;
            bus.mem_bw    = '1;
            bus.mem_a     = init_cnt;
            if (init_cnt == CNT_LAST) state_next = S_RUN;
          end else begin
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          bus.req_ready = credit;
          accept        = credit & bus.req_valid;
          if (accept) begin
            bus.mem_ce    = 1'b1;
            bus.mem_rdwen = bus.req_we;
            bus.mem_a     = bus.req_addr;
            bus.mem_di    = bus.req_wdata;
            bus.mem_bw    = bus.req_we ? bus.req_bw : '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
      rd_inflight <= accept & ~bus.req_we;
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // RAM DO is valid the cycle after a read strobe, which is exactly when rd_inflight is set.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_do;
  end
endmodule
